// File: rtl/zbt_pkg.sv
// Shared ZBT definitions: data-bus latency by part type, lane count and the
// read/write encoding used by the data pipe and the address/control stage.
package zbt_pkg;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Pipelined parts return data two cycles after the command, flow-through one.
  function automatic int data_lat(input int flow_thru);
    return (flow_thru != 0) ? 1 : 2;
  endfunction

  function automatic int num_lanes(input int data_bits, input int lane_bits);
    return data_bits / lane_bits;
  endfunction

endpackage

// File: rtl/zbt_lane_delay.sv
// Fixed-depth shift register with a synchronous reset value; every stage is
// exposed so the caller can tap the latency it needs.
module zbt_lane_delay #(
  parameter int             N       = 1,
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
  input  logic                  fpga_clk,
  input  logic                  reset,
  input  logic [W-1:0]          d,
  output logic [N-1:0][W-1:0]   taps
);

  logic [N-1:0][W-1:0] stage_r;

  // Shift one stage per clock; reset loads every stage with RST_VAL.
  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        stage_r[i] <= RST_VAL;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < N; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign taps = stage_r;

endmodule

// File: rtl/zbt_data_pipe.sv
// ZBT SRAM data-path pipe: aligns write data and per-lane tristate control to
// the bus and captures read data per lane, for pipelined or flow-through parts.
module zbt_data_pipe
  import zbt_pkg::*;
#(
  parameter int DATA_BITS = 36,
  parameter int LANE_BITS = 9,
  parameter int FLOW_THRU = 0,
  parameter int TAG_BITS  = 4
) (
  input  logic                 fpga_clk,
  input  logic                 reset,
  input  logic                 ui_valid,
  input  logic                 ui_rw_n,
  input  logic [TAG_BITS-1:0]  ui_tag,
  input  logic [DATA_BITS-1:0] ui_write_data,
  output logic [DATA_BITS-1:0] ui_read_data,
  output logic                 ui_read_valid,
  output logic [TAG_BITS-1:0]  ui_read_tag,
  output logic [DATA_BITS-1:0] write_data,
  input  logic [DATA_BITS-1:0] read_data,
  output logic [DATA_BITS-1:0] rw_tff
);

  localparam int DATA_LAT  = data_lat(FLOW_THRU);
  localparam int NUM_LANES = num_lanes(DATA_BITS, LANE_BITS);
  localparam int CTL_W     = 2 * NUM_LANES;
  // Control word per stage: {per-lane read flag, per-lane tristate}.
  localparam logic [CTL_W-1:0] CTL_RST = {{NUM_LANES{1'b0}}, {NUM_LANES{1'b1}}};

  if ((DATA_BITS % LANE_BITS) != 0) begin : g_lane_check
    $error("zbt_data_pipe: DATA_BITS must be a multiple of LANE_BITS");
  end

  logic                                cmd_tff_s;
  logic                                cmd_rd_s;
  logic [CTL_W-1:0]                    ctl_in_s;
  logic [DATA_BITS-1:0]                wd_in_s;
  logic [DATA_LAT:0][CTL_W-1:0]        ctl_taps_s;
  logic [DATA_LAT-1:0][DATA_BITS-1:0]  wd_taps_s;
  logic [DATA_LAT:0][TAG_BITS-1:0]     tag_taps_s;
  logic                                unused_taps_s;

  // Decode the command; read/NOP recirculate the newest write data so the bus holds still.
  always_comb begin
    cmd_tff_s = 1'b1;
    cmd_rd_s  = 1'b0;
    wd_in_s   = wd_taps_s[0];
    if (ui_valid && (ui_rw_n == RW_WRITE)) begin
      cmd_tff_s = 1'b0;
      wd_in_s   = ui_write_data;
    end else if (ui_valid && (ui_rw_n == RW_READ)) begin
      cmd_rd_s  = 1'b1;
    end else begin
      cmd_tff_s = 1'b1;
    end
  end

  assign ctl_in_s = {{NUM_LANES{cmd_rd_s}}, {NUM_LANES{cmd_tff_s}}};

  zbt_lane_delay #(.N(DATA_LAT + 1), .W(CTL_W), .RST_VAL(CTL_RST)) u_ctl_dly (
    .fpga_clk (fpga_clk),
    .reset    (reset),
    .d        (ctl_in_s),
    .taps     (ctl_taps_s)
  );

  zbt_lane_delay #(.N(DATA_LAT), .W(DATA_BITS), .RST_VAL({DATA_BITS{1'b0}})) u_wd_dly (
    .fpga_clk (fpga_clk),
    .reset    (reset),
    .d        (wd_in_s),
    .taps     (wd_taps_s)
  );

  zbt_lane_delay #(.N(DATA_LAT + 1), .W(TAG_BITS), .RST_VAL({TAG_BITS{1'b0}})) u_tag_dly (
    .fpga_clk (fpga_clk),
    .reset    (reset),
    .d        (ui_tag),
    .taps     (tag_taps_s)
  );

  assign write_data = wd_taps_s[DATA_LAT-1];

  // Each lane register drives only its own LANE_BITS pads.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign rw_tff[l*LANE_BITS +: LANE_BITS] = {LANE_BITS{ctl_taps_s[DATA_LAT-1][l]}};
  end

  // Read capture: each lane samples the pad register under its own delayed read flag.
  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      ui_read_data  <= {DATA_BITS{1'b0}};
      ui_read_valid <= 1'b0;
      ui_read_tag   <= {TAG_BITS{1'b0}};
    end else begin
      ui_read_valid <= ctl_taps_s[DATA_LAT][NUM_LANES];
      if (ctl_taps_s[DATA_LAT][NUM_LANES]) begin
        ui_read_tag <= tag_taps_s[DATA_LAT];
      end
      for (int l = 0; l < NUM_LANES; l++) begin
        if (ctl_taps_s[DATA_LAT][NUM_LANES + l]) begin
          ui_read_data[l*LANE_BITS +: LANE_BITS] <= read_data[l*LANE_BITS +: LANE_BITS];
        end
      end
    end
  end

  assign unused_taps_s = ^{ctl_taps_s, tag_taps_s};

endmodule

// File: doc/zbt_data_pipe.md
Name: zbt_data_pipe

Overview:
Parametrised data-path pipeline for the ZBT SRAM controller. It is the successor to the fixed 36-bit pipelined-only stage block. It aligns user write data and per-lane tristate control to the SRAM data bus, and captures read data per lane. The block supports both pipelined and flow-through ZBT parts, idle (NOP) cycles, and a read-valid strobe carrying a user tag. It sits between the controller's command stage and the data-bit IO cells.

Parameters:
DATA_BITS, 36, width of the SRAM data bus; must be a multiple of LANE_BITS.
LANE_BITS, 9, bits per byte lane (8 data + 1 parity); sets the fanout-tree grouping.
FLOW_THRU, 0, 0 = pipelined ZBT (DATA_LAT=2); 1 = flow-through ZBT (DATA_LAT=1).
TAG_BITS, 4, width of the user tag returned with read data.

Ports:
fpga_clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
ui_valid  input  1  command present this cycle; 0 = NOP.
ui_rw_n  input  1  1 = read, 0 = write; qualified by ui_valid.
ui_tag  input  TAG_BITS  tag for a read command; ignored for writes.
ui_write_data  input  DATA_BITS  write data, presented in the same cycle as the write command.
ui_read_data  output  DATA_BITS  captured read data.
ui_read_valid  output  1  one-cycle strobe; ui_read_data and ui_read_tag are valid.
ui_read_tag  output  TAG_BITS  tag of the returned read.
write_data  output  DATA_BITS  to IO cells, driven onto the SRAM bus.
read_data  input  DATA_BITS  from IO cells (input-registered at the pad).
rw_tff  output  DATA_BITS  per-bit tristate control; 1 = high-Z/read, 0 = drive.

Behaviour:
- NUM_LANES = DATA_BITS/LANE_BITS. A non-integer ratio is an elaboration error.
- A command is accepted at edge E0 when ui_valid=1 and reset=0.
- Reset values: rw_tff all 1 (bus released); write_data 0; ui_read_data 0; ui_read_valid 0; ui_read_tag 0; all internal pipeline valid bits 0.
- Drive path (write):
  - write_data and rw_tff update at edge E0+DATA_LAT-1.
  - Pipelined: E0+1, two register stages. Flow-through: E0, one stage.
- rw_tff value per command:
  - Write: 0 on every bit.
  - Read or NOP: 1.
- rw_tff construction:
  - Built from NUM_LANES lane registers, each replicated LANE_BITS times, so that no register fans out to more than LANE_BITS pads.
  - The first stage holds NUM_LANES copies of the command.
- write_data for read/NOP cycles: holds its previous value (no toggle while the bus is released).
- Capture path (read):
  - read_data is sampled at edge E0+DATA_LAT+1. Pipelined: E0+3. Flow-through: E0+2.
  - ui_read_data is updated per lane from its own lane copy of the delayed read flag.
  - ui_read_valid=1 and ui_read_tag=tag of that command become visible after the same edge, for exactly one cycle.
- Lanes not captured hold their value. Only read commands update ui_read_data; writes and NOPs never do.
- Back-to-back commands:
  - One command per cycle is accepted, with no turnaround bubbles.
  - Read→write and write→read switch rw_tff on consecutive cycles exactly as scheduled.
  - Continuous reads give ui_read_valid high on consecutive cycles with tags in order.
- Reset mid-operation: every in-flight command is discarded. No ui_read_valid for any command accepted before the reset edge, and none for a command presented during reset. rw_tff is forced to all 1 at the reset edge.
- After reset deasserts, the first command accepted at E0 follows normal latency. There is no extra warm-up cycle.
- Latency shift registers are sized from DATA_LAT; no logic depends on DATA_BITS=36.

Decomposition:
- Shared package zbt_pkg:
  - DATA_LAT function of FLOW_THRU.
  - NUM_LANES derivation.
  - Read/write encoding constants (RW_READ=1, RW_WRITE=0).
  - Shared with the address/control stage so that both use one latency definition.
- Sub-module zbt_lane_delay: a parametrised shift register of depth N and width W, with synchronous reset value. Instantiated three times:
  - rw/valid lane copies;
  - write data;
  - tag.

Test Plan:
- Pipelined, DATA_BITS=36: write 0x9_ABCD_1234 at E0 → rw_tff=0 and write_data=0x9_ABCD_1234 after E0+1, for one cycle; then rw_tff all 1.
- Pipelined: read with tag 5 at E0, read_data=0x1_2345_6789 held from E0+2 to E0+3 → ui_read_data=0x1_2345_6789, ui_read_valid=1, ui_read_tag=5 after E0+3, for one cycle only.
- FLOW_THRU=1: the same read → capture at E0+2; a write appears on write_data after E0.
- Alternating R(tag1), W, R(tag2), NOP → rw_tff pattern 1,0,1,1 on consecutive cycles; two valid strobes, two cycles apart, with tags 1 then 2; ui_read_data unchanged across the write.
- Reset asserted one cycle after a read is accepted → no ui_read_valid ever for that read; rw_tff all 1; ui_read_data 0.
- DATA_BITS=72, LANE_BITS=9: 8 consecutive reads with tags 0..7 → 8 consecutive strobes with tags in order; each lane of rw_tff is identical across its 9 bits.
